// File: rtl/div_seq_param.sv
// Sequential radix-2 restoring divider: DW-bit dividend by VW-bit divisor, one quotient
// bit per clock, unsigned or two's-complement per operation, valid/ready on both sides.
module div_seq_param #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          sgn,
  input  logic [DW-1:0] A,
  input  logic [VW-1:0] B,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] result,
  output logic [VW-1:0] odd,
  output logic          dz,
  output logic          ovf
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // in_ready is 1 only in IDLE; out_valid is 1 only in DONE, where outputs are held.
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);
  localparam logic [DW-1:0] DMIN = {1'b1, {(DW-1){1'b0}}};

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dq;
  logic [VW-1:0] rem, dvs;
  logic          neg_q, neg_r, ovf_p;

  logic          accept, last, ge;
  logic [DW-1:0] a_mag, dq_n, q_fix;
  logic [VW-1:0] b_mag, rem_n, r_fix;
  logic [VW:0]   pr, diff;

  assign accept = (state == IDLE) && in_valid;
  assign last   = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = (B == '0) ? DONE : BUSY;
      end
      BUSY: if (last) state_n = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // dq starts as |A| and shifts left each step; quotient bits fill in from the LSB.
  always_comb begin
    a_mag = (sgn && A[DW-1]) ? -A : A;
    b_mag = (sgn && B[VW-1]) ? -B : B;
    pr    = {rem, dq[DW-1]};
    diff  = pr - {1'b0, dvs};
    ge    = (pr >= {1'b0, dvs});
    rem_n = ge ? diff[VW-1:0] : pr[VW-1:0];
    dq_n  = {dq[DW-2:0], ge};
    q_fix = neg_q ? -dq_n : dq_n;
    r_fix = neg_r ? -rem_n : rem_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      dq     <= '0;
      rem    <= '0;
      dvs    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      ovf_p  <= 1'b0;
      result <= '0;
      odd    <= '0;
      dz     <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      dq    <= a_mag;
      rem   <= '0;
      dvs   <= b_mag;
      neg_q <= sgn & (A[DW-1] ^ B[VW-1]);
      neg_r <= sgn & A[DW-1];
      ovf_p <= sgn && (A == DMIN) && (B == '1);
      if (B == '0) begin
        result <= '1;
        odd    <= A[VW-1:0];
        dz     <= 1'b1;
        ovf    <= 1'b0;
      end
    end else if (state == BUSY) begin
      cnt <= cnt + 1'b1;
      dq  <= dq_n;
      rem <= rem_n;
      if (last) begin
        // Sign fix-up lands together with the final quotient bit.
        result <= q_fix;
        odd    <= r_fix;
        dz     <= 1'b0;
        ovf    <= ovf_p;
      end
    end
  end

endmodule

// File: tb/tb_div_seq_param.sv
// Bench for div_seq_param: directed corner cases plus randomized operations checked
// against an integer-arithmetic reference through an expected-result queue.
module tb_div_seq_param;

  localparam int DW = 16;
  localparam int VW = 8;
  localparam int EW = DW + VW + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          sgn = 1'b0;
  logic [DW-1:0] A = '0;
  logic [VW-1:0] B = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] result;
  logic [VW-1:0] odd;
  logic          dz;
  logic          ovf;

  logic [EW-1:0] exp_q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            acc_cyc = 0;
  bit            rand_rdy = 0;

  div_seq_param #(.DW(DW), .VW(VW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sgn(sgn),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .odd(odd), .dz(dz), .ovf(ovf)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: plain integer division; SV '/' and '%' on ints truncate toward zero
  // and give the remainder the dividend's sign.
  function automatic logic [EW-1:0] model(input logic s, input logic [DW-1:0] a,
                                          input logic [VW-1:0] b);
    int sa, sb;
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic z, ov;
    z = 1'b0;
    ov = 1'b0;
    if (b == '0) begin
      z = 1'b1;
      q = '1;
      r = a[VW-1:0];
    end else if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      q  = DW'(sa / sb);
      r  = VW'(sa % sb);
      ov = (sa == -(1 << (DW - 1))) && (sb == -1);
    end else begin
      sa = int'(a);
      sb = int'(b);
      q  = DW'(sa / sb);
      r  = VW'(sa % sb);
    end
    return {z, ov, q, r};
  endfunction

  // driver: present operands, push expectation at the accept edge, optionally
  // measure the accept-to-out_valid latency (accept edge counted as clock 1)
  task automatic issue(input logic s, input logic [DW-1:0] a, input logic [VW-1:0] b,
                       input bit wait_done);
    int n, lat;
    sgn = s;
    A = a;
    B = b;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    @(posedge clk);
    acc_cyc = cyc;
    exp_q.push_back(model(s, a, b));
    #1;
    in_valid = 1'b0;
    sgn = 1'($urandom);
    A = DW'($urandom);
    B = VW'($urandom);
    if (wait_done) begin
      lat = 1;
      while (!out_valid && lat < 64) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check("latency", lat, (b == '0) ? 1 : DW + 1);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        check("result", {dz, ovf, result, odd}, exp_q.pop_front());
      end
    end
  end

  initial begin
    int t0, n;
    logic [EW-1:0] held;
    logic [DW-1:0] a;
    logic [VW-1:0] b;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_outputs", {dz, ovf, result, odd}, 0);
    rst = 1'b0;

    issue(0, 16'd1000, 8'd7, 1);
    issue(1, 16'hFC18, 8'd7, 1);
    issue(0, 16'h1234, 8'd0, 1);
    issue(1, 16'h8000, 8'hFF, 1);
    issue(1, 16'h1234, 8'd0, 1);
    issue(1, 16'd1000, 8'hF9, 1);
    issue(0, 16'hFFFF, 8'hFF, 1);
    issue(0, 16'd5, 8'd9, 1);

    // stall in DONE
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    issue(0, 16'd40000, 8'd201, 1);
    held = model(0, 16'd40000, 8'd201);
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_hold", {dz, ovf, result, odd}, held);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // back-to-back spacing with out_ready held high
    issue(1, 16'hABCD, 8'h35, 1);
    t0 = acc_cyc;
    issue(0, 16'h0F0F, 8'h11, 1);
    check("throughput", acc_cyc - t0, DW + 2);

    // reset in the middle of an operation
    issue(0, 16'd5000, 8'd13, 0);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_outputs", {dz, ovf, result, odd}, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(0, 16'd5000, 8'd13, 1);
    issue(1, 16'h8001, 8'h80, 1);

    // randomized traffic with a random consumer
    rand_rdy = 1;
    for (int i = 0; i < 150; i++) begin
      a = DW'($urandom);
      b = ($urandom_range(0, 9) == 0) ? '0 : VW'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        a = 16'h8000;
        b = 8'hFF;
      end
      issue(1'($urandom_range(0, 1)), a, b, 1);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
    rand_rdy = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
